// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared opcode, writeback-select and store-kind definitions
package mem_stage_pkg;

  // Memory opcodes from instr[31:26]
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  // Writeback select encodings
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC8 = 2'b10;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_WORD = 2'd1,
    ST_HALF = 2'd2,
    ST_BYTE = 2'd3
  } store_kind_e;

  // Map an opcode to the store width it performs (ST_NONE for non-stores)
  function automatic store_kind_e decode_store(input logic [5:0] op);
    case (op)
      OP_SW:   return ST_WORD;
      OP_SH:   return ST_HALF;
      OP_SB:   return ST_BYTE;
      default: return ST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_dm.sv
// rtl/mem_stage_dm.sv - data memory array with store lane merge and reset clear
module dm
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  store_kind_e       store_kind,
  input  logic [DM_AW-1:0]  word_idx,
  input  logic [1:0]        byte_off,
  input  logic [31:0]       store_data,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DM_WORDS];
  logic [31:0] word_d;
  logic        we;

  // Asynchronous read: loads see the pre-write contents during a store cycle
  assign rdata = mem_q[word_idx];

  // Merge the store lanes into the currently addressed word
  always_comb begin
    word_d = rdata;
    we     = 1'b1;
    case (store_kind)
      ST_WORD: word_d = store_data;
      ST_HALF: begin
        if (byte_off[1]) word_d[31:16] = store_data[15:0];
        else             word_d[15:0]  = store_data[15:0];
      end
      ST_BYTE: word_d[8*byte_off +: 8] = store_data[7:0];
      default: we = 1'b0;
    endcase
  end

  // Array update; reset clears every word and suppresses any pending write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[word_idx] <= word_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM pipeline register, data memory and load extension
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_E,
  input  logic [1:0]  Mem2Reg_E,
  input  logic [4:0]  WRegAdd_E,
  input  logic [31:0] ALUout_E,
  input  logic [31:0] WriteData_E,
  input  logic [31:0] instr_E,
  input  logic [31:0] PC8_E,
  input  logic        ForwardRTM,
  input  logic [31:0] result_W,
  output logic        RegWrite_M,
  output logic [1:0]  Mem2Reg_M,
  output logic [4:0]  WRegAdd_M,
  output logic [31:0] ALUout_M,
  output logic [31:0] instr_M,
  output logic [31:0] PC8_M,
  output logic [31:0] ReadData_M
);

  logic        reg_write_q, reg_write_d;
  logic [1:0]  mem2reg_q,   mem2reg_d;
  logic [4:0]  wreg_q,      wreg_d;
  logic [31:0] alu_q,       alu_d;
  logic [31:0] wdata_q,     wdata_d;
  logic [31:0] instr_q,     instr_d;
  logic [31:0] pc8_q,       pc8_d;

  logic [5:0]  opcode;
  logic [31:0] store_data;
  logic [31:0] word;
  logic [15:0] half;
  logic [7:0]  byte_v;

  // Next state of the pipeline register: straight capture of the EX stage
  always_comb begin
    reg_write_d = RegWrite_E;
    mem2reg_d   = Mem2Reg_E;
    wreg_d      = WRegAdd_E;
    alu_d       = ALUout_E;
    wdata_d     = WriteData_E;
    instr_d     = instr_E;
    pc8_d       = PC8_E;
  end

  // EX/MEM register; reset turns the M stage into a nop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      mem2reg_q   <= '0;
      wreg_q      <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      instr_q     <= '0;
      pc8_q       <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      mem2reg_q   <= mem2reg_d;
      wreg_q      <= wreg_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      instr_q     <= instr_d;
      pc8_q       <= pc8_d;
    end
  end

  assign opcode     = instr_q[31:26];
  assign store_data = ForwardRTM ? result_W : wdata_q;

  dm #(
    .DM_WORDS (DM_WORDS),
    .DM_AW    (DM_AW)
  ) u_dm (
    .clk        (clk),
    .reset      (reset),
    .store_kind (decode_store(opcode)),
    .word_idx   (alu_q[DM_AW+1:2]),
    .byte_off   (alu_q[1:0]),
    .store_data (store_data),
    .rdata      (word)
  );

  // Select and extend the loaded lane; non-loads read as zero
  always_comb begin
    half   = alu_q[1] ? word[31:16] : word[15:0];
    byte_v = word[8*alu_q[1:0] +: 8];
    case (opcode)
      OP_LW:   ReadData_M = word;
      OP_LH:   ReadData_M = {{16{half[15]}}, half};
      OP_LHU:  ReadData_M = {16'h0000, half};
      OP_LB:   ReadData_M = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  ReadData_M = {24'h000000, byte_v};
      default: ReadData_M = '0;
    endcase
  end

  assign RegWrite_M = reg_write_q;
  assign Mem2Reg_M  = mem2reg_q;
  assign WRegAdd_M  = wreg_q;
  assign ALUout_M   = alu_q;
  assign instr_M    = instr_q;
  assign PC8_M      = pc8_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        RegWrite_E;
  logic [1:0]  Mem2Reg_E;
  logic [4:0]  WRegAdd_E;
  logic [31:0] ALUout_E;
  logic [31:0] WriteData_E;
  logic [31:0] instr_E;
  logic [31:0] PC8_E;
  logic        ForwardRTM;
  logic [31:0] result_W;
  logic        RegWrite_M;
  logic [1:0]  Mem2Reg_M;
  logic [4:0]  WRegAdd_M;
  logic [31:0] ALUout_M;
  logic [31:0] instr_M;
  logic [31:0] PC8_M;
  logic [31:0] ReadData_M;

  int checks = 0;
  int fails  = 0;

  mem_stage dut (
    .clk         (clk),
    .reset       (reset),
    .RegWrite_E  (RegWrite_E),
    .Mem2Reg_E   (Mem2Reg_E),
    .WRegAdd_E   (WRegAdd_E),
    .ALUout_E    (ALUout_E),
    .WriteData_E (WriteData_E),
    .instr_E     (instr_E),
    .PC8_E       (PC8_E),
    .ForwardRTM  (ForwardRTM),
    .result_W    (result_W),
    .RegWrite_M  (RegWrite_M),
    .Mem2Reg_M   (Mem2Reg_M),
    .WRegAdd_M   (WRegAdd_M),
    .ALUout_M    (ALUout_M),
    .instr_M     (instr_M),
    .PC8_M       (PC8_M),
    .ReadData_M  (ReadData_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a memory-type instruction into EX with default control fields
  task automatic ex(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
    RegWrite_E  = 1'b0;
    Mem2Reg_E   = M2R_ALU;
    WRegAdd_E   = 5'd0;
    ALUout_E    = addr;
    WriteData_E = wd;
    instr_E     = {op, 26'h0};
    PC8_E       = 32'h0;
  endtask

  initial begin
    reset      = 1'b1;
    ForwardRTM = 1'b0;
    result_W   = 32'h0;
    ex(6'h00, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: store, read back, then reset mid-run
    ex(OP_SW, 32'h0, 32'h12345678);
    step();
    ex(OP_LW, 32'h0, 32'h0);
    step();
    chk("pre_reset_lw", ReadData_M, 32'h12345678);
    ex(OP_LW, 32'h0, 32'h0);
    RegWrite_E = 1'b1; Mem2Reg_E = M2R_MEM; WRegAdd_E = 5'd5; PC8_E = 32'h100;
    step();
    chk("pre_reset_regwrite", {31'h0, RegWrite_M}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("rst_regwrite", {31'h0, RegWrite_M}, 32'h0);
    chk("rst_mem2reg",  {30'h0, Mem2Reg_M},  32'h0);
    chk("rst_wregadd",  {27'h0, WRegAdd_M},  32'h0);
    chk("rst_aluout",   ALUout_M,   32'h0);
    chk("rst_instr",    instr_M,    32'h0);
    chk("rst_pc8",      PC8_M,      32'h0);
    chk("rst_readdata", ReadData_M, 32'h0);
    ex(6'h00, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    ex(OP_LW, 32'h0, 32'h0);
    step();
    chk("post_reset_lw", ReadData_M, 32'h00000000);

    // 2: word path, plus high address bits ignored
    ex(OP_SW, 32'h10, 32'hDEADBEEF);
    step();
    ex(OP_LW, 32'h10, 32'h0);
    step();
    chk("lw_word", ReadData_M, 32'hDEADBEEF);
    ex(OP_LW, 32'h1010, 32'h0);
    step();
    chk("lw_alias", ReadData_M, 32'hDEADBEEF);

    // 3: byte and half lanes
    ex(OP_SB, 32'h23, 32'hFFFFFF80);
    step();
    ex(OP_LW, 32'h20, 32'h0);
    step();
    chk("sb_word", ReadData_M, 32'h80000000);
    ex(OP_LB, 32'h23, 32'h0);
    step();
    chk("lb_sign", ReadData_M, 32'hFFFFFF80);
    ex(OP_LBU, 32'h23, 32'h0);
    step();
    chk("lbu_zero", ReadData_M, 32'h00000080);
    ex(OP_SH, 32'h22, 32'h1234ABCD);
    step();
    ex(OP_LW, 32'h20, 32'h0);
    step();
    chk("sh_word", ReadData_M, 32'hABCD0000);
    ex(OP_LH, 32'h22, 32'h0);
    step();
    chk("lh_sign", ReadData_M, 32'hFFFFABCD);
    ex(OP_LHU, 32'h22, 32'h0);
    step();
    chk("lhu_zero", ReadData_M, 32'h0000ABCD);
    ex(OP_SB, 32'h21, 32'h0000005A);
    step();
    ex(OP_LW, 32'h20, 32'h0);
    step();
    chk("sb_lane1", ReadData_M, 32'hABCD5A00);
    ex(OP_LB, 32'h21, 32'h0);
    step();
    chk("lb_pos", ReadData_M, 32'h0000005A);

    // 4: load-to-store forwarding
    ex(OP_SW, 32'h30, 32'h00000001);
    ForwardRTM = 1'b1;
    result_W   = 32'hCAFEF00D;
    step();
    ex(OP_LW, 32'h30, 32'h0);
    step();
    ForwardRTM = 1'b0;
    result_W   = 32'h0;
    chk("fwd_lw", ReadData_M, 32'hCAFEF00D);

    // 5: control passthrough
    ex(6'h00, 32'h55, 32'h0);
    RegWrite_E = 1'b1; WRegAdd_E = 5'd31; Mem2Reg_E = M2R_PC8; PC8_E = 32'h3008;
    instr_E = 32'h03E0F821;
    step();
    chk("pt_regwrite", {31'h0, RegWrite_M}, 32'h1);
    chk("pt_wregadd",  {27'h0, WRegAdd_M},  32'd31);
    chk("pt_mem2reg",  {30'h0, Mem2Reg_M},  32'h2);
    chk("pt_pc8",      PC8_M,    32'h3008);
    chk("pt_aluout",   ALUout_M, 32'h55);
    chk("pt_instr",    instr_M,  32'h03E0F821);

    // 6: non-memory instruction leaves memory alone
    ex(OP_SW, 32'h40, 32'h11223344);
    step();
    ex(6'h00, 32'h40, 32'hFFFFFFFF);
    instr_E = 32'h00851021;
    step();
    chk("addu_readdata", ReadData_M, 32'h0);
    ex(OP_LW, 32'h40, 32'h0);
    step();
    chk("addu_nowrite", ReadData_M, 32'h11223344);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
